// File: rtl/id_unidad_deteccion_riesgos.sv
`default_nettype none
// ============================================================================
// Module   : id_unidad_deteccion_riesgos
// Purpose  : ID-stage hazard detection. Raises bubble requests for load-use
//            and branch-operand hazards, flushes IF/ID on taken branches and
//            jumps, and drains the pipeline after HALT before flagging halted.
// Revision : 1.0 - initial release
// ============================================================================
module id_unidad_deteccion_riesgos #(
  parameter int NB_REG       = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_CNT       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_Step,
  input  logic [NB_REG-1:0] i_ID_rs,
  input  logic [NB_REG-1:0] i_ID_rt,
  input  logic              i_ID_UsesRt,
  input  logic              i_ID_Branch,
  input  logic              i_ID_JALR,
  input  logic              i_ID_Taken,
  input  logic              i_ID_HALT,
  input  logic              i_EX_MemRead,
  input  logic              i_EX_RegWrite,
  input  logic [NB_REG-1:0] i_EX_Dest,
  input  logic              i_MEM_MemRead,
  input  logic [NB_REG-1:0] i_MEM_Dest,
  output logic              o_Riesgo,
  output logic              o_PCWrite,
  output logic              o_IFIDWrite,
  output logic              o_IFIDFlush,
  output logic              o_Halted,
  output logic [NB_CNT-1:0] o_StallCount
);

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);
  localparam logic [NB_CNT-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q;
  logic [NB_DRAIN-1:0] drain_cnt_q;
  logic                halted_q;
  logic [NB_CNT-1:0]   stall_cnt_q;
  logic [NB_CNT-1:0]   stall_cnt_d;

  logic w_load_use;
  logic w_br_ex;
  logic w_br_mem;
  logic w_br_haz;
  logic w_stall;

  // Register 0 is hardwired, so it can never be a true dependency.
  function automatic logic match(input logic [NB_REG-1:0] a,
                                 input logic [NB_REG-1:0] d);
    return (a == d) && (d != '0);
  endfunction

  // Hazard detection: rt counts for load-use only when the ID instruction
  // reads it; branches always compare rs and rt, JR/JALR only rs.
  always_comb begin
    w_load_use = i_EX_MemRead &
                 (match(i_ID_rs, i_EX_Dest) |
                  (i_ID_UsesRt & match(i_ID_rt, i_EX_Dest)));
    w_br_ex    = i_EX_RegWrite &
                 (match(i_ID_rs, i_EX_Dest) |
                  (i_ID_Branch & match(i_ID_rt, i_EX_Dest)));
    w_br_mem   = i_MEM_MemRead &
                 (match(i_ID_rs, i_MEM_Dest) |
                  (i_ID_Branch & match(i_ID_rt, i_MEM_Dest)));
    w_br_haz   = (i_ID_Branch | i_ID_JALR) & (w_br_ex | w_br_mem);
    w_stall    = w_load_use | w_br_haz;
  end

  // Pipeline control outputs; a frozen step never lets PC or IF/ID move.
  always_comb begin
    o_Riesgo    = 1'b0;
    o_PCWrite   = 1'b0;
    o_IFIDWrite = 1'b0;
    o_IFIDFlush = 1'b0;
    case (state_q)
      ST_RUN: begin
        o_Riesgo    = w_stall;
        o_PCWrite   = i_Step & ~w_stall;
        o_IFIDWrite = i_Step & ~w_stall;
        o_IFIDFlush = i_Step & ~w_stall & i_ID_Taken;
      end
      ST_DRAIN: begin
        // Feed only bubbles behind HALT while it moves to WB.
        o_Riesgo    = 1'b1;
        o_IFIDWrite = i_Step;
        o_IFIDFlush = i_Step;
      end
      ST_HALTED: begin
        o_Riesgo = 1'b1;
      end
      default: begin
        o_Riesgo = 1'b1;
      end
    endcase
  end

  assign o_Halted     = halted_q;
  assign o_StallCount = stall_cnt_q;

  // Saturating count of bubbles inserted by real hazards.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && w_stall && i_Step && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // HALT drain state machine: RUN -> DRAIN -> HALTED, exit only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else if (i_Step) begin
      case (state_q)
        ST_RUN: begin
          if (i_ID_HALT && !w_stall) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          drain_cnt_q <= '0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_unidad_deteccion_riesgos.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_unidad_deteccion_riesgos
// Purpose  : Scoreboard bench for the ID hazard detection unit. A driver
//            issues directed then random stimulus and queues the outputs a
//            behavioural model predicts; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_unidad_deteccion_riesgos;

  localparam int NB_REG       = 5;
  localparam int DRAIN_CYCLES = 4;
  localparam int NB_CNT       = 2;
  localparam int CNT_SAT      = (1 << NB_CNT) - 1;

  typedef struct {
    bit       reset;
    bit       step;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       uses_rt;
    bit       branch;
    bit       jalr;
    bit       taken;
    bit       halt;
    bit       ex_mr;
    bit       ex_rw;
    bit [4:0] ex_dest;
    bit       mem_mr;
    bit [4:0] mem_dest;
  } in_t;

  typedef struct {
    bit riesgo;
    bit pcw;
    bit ifidw;
    bit flush;
    bit halted;
    int cnt;
  } exp_t;

  logic              clk;
  logic              i_reset;
  logic              i_Step;
  logic [NB_REG-1:0] i_ID_rs;
  logic [NB_REG-1:0] i_ID_rt;
  logic              i_ID_UsesRt;
  logic              i_ID_Branch;
  logic              i_ID_JALR;
  logic              i_ID_Taken;
  logic              i_ID_HALT;
  logic              i_EX_MemRead;
  logic              i_EX_RegWrite;
  logic [NB_REG-1:0] i_EX_Dest;
  logic              i_MEM_MemRead;
  logic [NB_REG-1:0] i_MEM_Dest;
  logic              o_Riesgo;
  logic              o_PCWrite;
  logic              o_IFIDWrite;
  logic              o_IFIDFlush;
  logic              o_Halted;
  logic [NB_CNT-1:0] o_StallCount;

  id_unidad_deteccion_riesgos #(
    .NB_REG      (NB_REG),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .NB_CNT      (NB_CNT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_Step       (i_Step),
    .i_ID_rs      (i_ID_rs),
    .i_ID_rt      (i_ID_rt),
    .i_ID_UsesRt  (i_ID_UsesRt),
    .i_ID_Branch  (i_ID_Branch),
    .i_ID_JALR    (i_ID_JALR),
    .i_ID_Taken   (i_ID_Taken),
    .i_ID_HALT    (i_ID_HALT),
    .i_EX_MemRead (i_EX_MemRead),
    .i_EX_RegWrite(i_EX_RegWrite),
    .i_EX_Dest    (i_EX_Dest),
    .i_MEM_MemRead(i_MEM_MemRead),
    .i_MEM_Dest   (i_MEM_Dest),
    .o_Riesgo     (o_Riesgo),
    .o_PCWrite    (o_PCWrite),
    .o_IFIDWrite  (o_IFIDWrite),
    .o_IFIDFlush  (o_IFIDFlush),
    .o_Halted     (o_Halted),
    .o_StallCount (o_StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_mode   = 0;   // 0 running, 1 draining, 2 halted
  int   m_done   = 0;   // stepped cycles since HALT left ID
  int   m_cnt    = 0;

  function automatic bit hit(bit [4:0] a, bit [4:0] d);
    return (a == d) && (d != 0);
  endfunction

  function automatic bit hazard(in_t s);
    bit lu, bh;
    lu = s.ex_mr && (hit(s.rs, s.ex_dest) || (s.uses_rt && hit(s.rt, s.ex_dest)));
    bh = 0;
    if (s.branch || s.jalr) begin
      if (s.ex_rw && hit(s.rs, s.ex_dest)) bh = 1;
      if (s.mem_mr && hit(s.rs, s.mem_dest)) bh = 1;
      if (s.branch && s.ex_rw && hit(s.rt, s.ex_dest)) bh = 1;
      if (s.branch && s.mem_mr && hit(s.rt, s.mem_dest)) bh = 1;
    end
    return lu || bh;
  endfunction

  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    s.step = 1;
    return s;
  endfunction

  task automatic drive(input in_t s, input bit do_check);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    i_reset = s.reset;       i_Step = s.step;
    i_ID_rs = s.rs;          i_ID_rt = s.rt;
    i_ID_UsesRt = s.uses_rt; i_ID_Branch = s.branch;
    i_ID_JALR = s.jalr;      i_ID_Taken = s.taken;
    i_ID_HALT = s.halt;      i_EX_MemRead = s.ex_mr;
    i_EX_RegWrite = s.ex_rw; i_EX_Dest = s.ex_dest;
    i_MEM_MemRead = s.mem_mr; i_MEM_Dest = s.mem_dest;
    hz = hazard(s);
    e = '{default: 0};
    e.cnt = m_cnt;
    if (m_mode == 0) begin
      e.riesgo = hz;
      e.pcw    = s.step && !hz;
      e.ifidw  = s.step && !hz;
      e.flush  = s.step && !hz && s.taken;
    end else if (m_mode == 1) begin
      e.riesgo = 1;
      e.ifidw  = s.step;
      e.flush  = s.step;
    end else begin
      e.riesgo = 1;
      e.halted = 1;
    end
    if (do_check) q.push_back(e);
    // Advance the model to the state after this clock edge
    if (s.reset) begin
      m_mode = 0; m_done = 0; m_cnt = 0;
    end else if (s.step) begin
      if (m_mode == 0) begin
        if (hz) m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
        else if (s.halt) begin m_mode = 1; m_done = 0; end
      end else if (m_mode == 1) begin
        m_done++;
        if (m_done == DRAIN_CYCLES) m_mode = 2;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are compared mid-cycle against the queued prediction
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("riesgo",  int'(o_Riesgo),     int'(e.riesgo));
      chk("pcwrite", int'(o_PCWrite),    int'(e.pcw));
      chk("ifidwr",  int'(o_IFIDWrite),  int'(e.ifidw));
      chk("flush",   int'(o_IFIDFlush),  int'(e.flush));
      chk("halted",  int'(o_Halted),     int'(e.halted));
      chk("stallcnt", int'(o_StallCount), e.cnt);
    end
  end

  task automatic do_reset();
    in_t s;
    s = idle();
    s.reset = 1;
    drive(s, 1);
  endtask

  initial begin
    in_t s;
    // Power-up reset without checks: the state is unknown until the first edge
    s = idle(); s.reset = 1;
    drive(s, 0);
    drive(s, 0);

    // Reset state
    s = idle(); drive(s, 1);

    // Load-use on rs, then dependency gone
    s = idle(); s.ex_mr = 1; s.ex_dest = 3; s.rs = 3; drive(s, 1);
    s = idle(); s.ex_dest = 7; s.rs = 3; drive(s, 1);

    // Register 0 and unused rt never stall
    s = idle(); s.ex_mr = 1; s.ex_dest = 0; s.rs = 0; drive(s, 1);
    s = idle(); s.ex_mr = 1; s.ex_dest = 5; s.rt = 5; s.rs = 1; drive(s, 1);

    // Branch operand on rt: EX ALU producer, then MEM load, then taken
    s = idle(); s.branch = 1; s.rs = 1; s.rt = 4; s.ex_rw = 1; s.ex_dest = 4; drive(s, 1);
    s = idle(); s.branch = 1; s.rs = 1; s.rt = 4; s.mem_mr = 1; s.mem_dest = 4; drive(s, 1);
    s = idle(); s.branch = 1; s.rs = 1; s.rt = 4; s.taken = 1; drive(s, 1);
    // JR reads only rs
    s = idle(); s.jalr = 1; s.rs = 2; s.rt = 6; s.ex_rw = 1; s.ex_dest = 6; drive(s, 1);
    s = idle(); s.jalr = 1; s.rs = 6; s.ex_rw = 1; s.ex_dest = 6; drive(s, 1);

    // Taken while load-use stalls, then taken with no hazard
    do_reset();
    s = idle(); s.taken = 1; s.ex_mr = 1; s.ex_dest = 9; s.rt = 9; s.uses_rt = 1; drive(s, 1);
    s = idle(); s.taken = 1; drive(s, 1);

    // HALT blocked by a stall, then drained with a 3-cycle freeze
    s = idle(); s.halt = 1; s.ex_mr = 1; s.ex_dest = 2; s.rs = 2; drive(s, 1);
    s = idle(); s.halt = 1; drive(s, 1);
    s = idle(); drive(s, 1);
    s = idle(); s.step = 0; repeat (3) drive(s, 1);
    s = idle(); repeat (4) drive(s, 1);
    s = idle(); s.step = 0; drive(s, 1);
    do_reset();
    s = idle(); drive(s, 1);

    // Saturation: five consecutive stalls
    s = idle(); s.ex_mr = 1; s.ex_dest = 8; s.rs = 8; repeat (5) drive(s, 1);
    s = idle(); drive(s, 1);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s.reset    = ($urandom_range(0, 59) == 0);
      s.step     = ($urandom_range(0, 3) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.branch   = ($urandom_range(0, 3) == 0);
      s.jalr     = ($urandom_range(0, 5) == 0);
      s.taken    = 1'($urandom_range(0, 1));
      s.halt     = ($urandom_range(0, 24) == 0);
      s.ex_mr    = ($urandom_range(0, 2) == 0);
      s.ex_rw    = 1'($urandom_range(0, 1));
      s.ex_dest  = 5'($urandom_range(0, 3));
      s.mem_mr   = ($urandom_range(0, 2) == 0);
      s.mem_dest = 5'($urandom_range(0, 3));
      drive(s, 1);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
